frog_motion_ctrl: RTL
=====================

// Module: frog_motion_ctrl
// PURPOSE
//  Upstream stage of the frame renderer: owns the frog sprite position (BallX/BallY) consumed by the draw logic.
//  Turns USB keycodes into animated lane hops, applies log/turtle drift, and runs death/respawn/lives sequencing.
//  All motion is paced by the VGA frame pulse, so the renderer sees at most one position change per frame.
// PARAMETERS
//  START_X      10'd312  respawn X (pixels, sprite top-left)
//  START_Y      10'd422  respawn Y (bottom safe strip)
//  MIN_Y        10'd92   topmost legal Y (home row)
//  MAX_X        10'd622  rightmost legal X (640 - 17 + 1 - 2 margin)
//  HOP_PIX      30       pixels per hop, both axes
//  HOP_FRAMES   6        frames per hop; HOP_PIX % HOP_FRAMES == 0 (step 5 px/frame)
//  DEATH_FRAMES 60       frames the dead sprite is held before respawn
//  LIVES_INIT   2'd3     lives after reset
// PORTS
//  Clk        in   1   system clock
//  Reset_n    in   1   asynchronous reset, active low
//  frame_clk  in   1   VGA vsync-derived level; rising edge = one frame tick
//  keycode    in   8   USB keycode; W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right, 0=none
//  die        in   1   collision/drown pulse from hit detection
//  drift_dx   in   4   signed px/frame from object the frog rides (0 when not riding)
//  BallX      out  10  frog X
//  BallY      out  10  frog Y
//  dead       out  1   high in DEAD (renderer swaps in skull sprite)
//  lives      out  2   remaining lives
//  game_over  out  1   high in OVER
//  hop_done   out  1   one-cycle pulse when a hop completes
//  hop_up     out  1   qualifies hop_done: 1 = upward hop (score event)
// BEHAVIOUR
//  Reset (async, Reset_n=0): BallX=START_X, BallY=START_Y, lives=LIVES_INIT, state IDLE, all flags 0, key/frame history 0.
//  frame_tick = frame_clk sampled high this cycle and low previous cycle (2-FF sync, then edge detect).
//  key_new = keycode in {W,A,S,D} and keycode != keycode sampled previous cycle; holding a key never repeats.
//  FSM IDLE / HOP / DEAD / OVER:
//   IDLE: key_new whose target (pos +/- HOP_PIX) lies in X[0,MAX_X], Y[MIN_Y,START_Y] -> HOP, latch dir, frame cnt=0.
//         Out-of-range target: key ignored, stay IDLE, no pulse.
//         frame_tick: BallX += sign-extended drift_dx, saturated to [0,MAX_X] (no underflow wrap).
//   HOP:  each frame_tick moves HOP_PIX/HOP_FRAMES px in latched dir, cnt++; keys ignored, drift not applied.
//         Tick with cnt==HOP_FRAMES-1 makes final step; next cycle hop_done=1 (hop_up=1 if dir up), -> IDLE.
//         Hop = exactly HOP_PIX px after HOP_FRAMES ticks; first step on first tick after entry.
//   DEAD: entered on die in IDLE or HOP; dead=1, position frozen, cnt cleared; die/keys ignored.
//         After DEATH_FRAMES ticks: if lives==1 -> lives=0, OVER; else lives-=1, BallX/Y=START, -> IDLE.
//   OVER: game_over=1, dead=1, all inputs ignored until Reset_n.
//  Priority same cycle: die > hop completion > key_new > drift. die on final hop tick -> DEAD, no hop_done.
//  key_new and frame_tick same cycle in IDLE: hop starts, drift for that tick is dropped.
//  Reset_n mid-hop or mid-death: immediate return to reset values; partial hop discarded.
//  Arithmetic: positions 10-bit unsigned; signed math in 11 bits then clamped; all outputs registered.
// TESTING
//  Reset, W pressed once -> HOP; after 6 frame ticks BallY=392, BallX=312, hop_done+hop_up pulse once.
//  Hold W 20 frames -> exactly one hop (BallY 422->392); release/re-press -> second hop to 362.
//  At BallY=422 press S; at BallX=0 press A -> ignored, no HOP, no hop_done; position unchanged.
//  IDLE at BallX=620, drift_dx=+3 for 2 ticks -> BallX=622; BallX=2, drift_dx=-4 -> BallX=0.
//  die on 3rd hop tick -> dead=1, position frozen; after 60 ticks BallX/Y=312/422, lives=2, no hop_done.
//  Three deaths from reset -> lives 3,2,1,0; game_over=1, keys ignored; Reset_n low mid-hop restores start.

Source files
------------

// File: rtl/frog_motion_ctrl.sv
// frog_motion_ctrl
//   Owns the frog sprite position for the renderer. It turns new WASD keycodes
//   into animated lane hops, applies log/turtle drift while idle, and sequences
//   death, respawn, lives and game over. All motion is paced by the frame tick.
//
// Ports
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   frame_clk           vsync-derived level; rising edge = one frame tick
//   keycode[7:0]        USB keycode (W=1A up, S=16 down, A=04 left, D=07 right)
//   die                 collision/drown pulse
//   drift_dx[3:0]       signed px/frame from the object being ridden
//   BallX/BallY[9:0]    frog sprite top-left position
//   dead                skull sprite select (DEAD and OVER)
//   lives[1:0]          remaining lives
//   game_over           high in OVER
//   hop_done, hop_up    one-cycle hop completion pulse, qualified by direction
//   dbg_state_o[1:0]    FSM state (0 IDLE, 1 HOP, 2 DEAD, 3 OVER)
//
// Handshake note: there is no valid/ready flow here; keycode is level-sampled
// and only a change to a move key counts, and hop_done is a single-cycle pulse
// with hop_up valid only in that same cycle.
module frog_motion_ctrl #(
  parameter logic [9:0] START_X      = 10'd312,
  parameter logic [9:0] START_Y      = 10'd422,
  parameter logic [9:0] MIN_Y        = 10'd92,
  parameter logic [9:0] MAX_X        = 10'd622,
  parameter int         HOP_PIX      = 30,
  parameter int         HOP_FRAMES   = 6,
  parameter int         DEATH_FRAMES = 60,
  parameter logic [1:0] LIVES_INIT   = 2'd3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       die,
  input  logic [3:0] drift_dx,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic       dead,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       hop_done,
  output logic       hop_up,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOP = 2'd1, S_DEAD = 2'd2, S_OVER = 2'd3} state_t;
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [9:0] HOP_PIX_W  = 10'(HOP_PIX);
  localparam logic [9:0] HOP_STEP   = 10'(HOP_PIX / HOP_FRAMES);
  localparam logic [5:0] HOP_LAST   = 6'(HOP_FRAMES - 1);
  localparam logic [5:0] DEATH_LAST = 6'(DEATH_FRAMES - 1);

  state_t     state_q;
  dir_t       dir_q;
  logic [5:0] cnt_q;
  logic [9:0] x_q, y_q;
  logic [1:0] lives_q;
  logic       dead_q, over_q, hop_done_q, hop_up_q;
  logic       fsync1_q, fsync2_q, fprev_q;
  logic [7:0] key_prev_q;

  logic       frame_tick;
  logic       key_new;
  logic       target_ok;
  dir_t       key_dir;
  logic [10:0] drift_sum;
  logic [9:0]  drift_x_d;

  assign frame_tick = fsync2_q & ~fprev_q;

  // Target legality and direction decode for the current keycode.
  always_comb begin
    target_ok = 1'b0;
    key_dir   = D_UP;
    key_new   = 1'b0;
    case (keycode)
      KEY_W: begin key_dir = D_UP;    target_ok = (y_q >= MIN_Y + HOP_PIX_W);   end
      KEY_S: begin key_dir = D_DOWN;  target_ok = (y_q + HOP_PIX_W <= START_Y); end
      KEY_A: begin key_dir = D_LEFT;  target_ok = (x_q >= HOP_PIX_W);           end
      KEY_D: begin key_dir = D_RIGHT; target_ok = (x_q + HOP_PIX_W <= MAX_X);   end
      default: begin key_dir = D_UP; target_ok = 1'b0; end
    endcase
    if ((keycode == KEY_W) || (keycode == KEY_S) || (keycode == KEY_A) || (keycode == KEY_D))
      key_new = (keycode != key_prev_q);
  end

  // Drift in 11 bits: x is at most MAX_X and |drift| <= 8, so bit 10 set can
  // only mean the sum went negative.
  always_comb begin
    drift_sum = {1'b0, x_q} + {{7{drift_dx[3]}}, drift_dx};
    drift_x_d = drift_sum[9:0];
    if (drift_sum[10])
      drift_x_d = 10'd0;
    else if (drift_sum[9:0] > MAX_X)
      drift_x_d = MAX_X;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      dir_q      <= D_UP;
      cnt_q      <= '0;
      x_q        <= START_X;
      y_q        <= START_Y;
      lives_q    <= LIVES_INIT;
      dead_q     <= 1'b0;
      over_q     <= 1'b0;
      hop_done_q <= 1'b0;
      hop_up_q   <= 1'b0;
      fsync1_q   <= 1'b0;
      fsync2_q   <= 1'b0;
      fprev_q    <= 1'b0;
      key_prev_q <= '0;
    end else begin
      fsync1_q   <= frame_clk;
      fsync2_q   <= fsync1_q;
      fprev_q    <= fsync2_q;
      key_prev_q <= keycode;
      hop_done_q <= 1'b0;
      hop_up_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (die) begin
            state_q <= S_DEAD;
            dead_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (key_new && target_ok) begin
            // A tick arriving in this same cycle is dropped on purpose.
            state_q <= S_HOP;
            dir_q   <= key_dir;
            cnt_q   <= '0;
          end else if (frame_tick) begin
            x_q <= drift_x_d;
          end
        end
        S_HOP: begin
          if (die) begin
            // Death beats the final step: no hop_done for a killed hop.
            state_q <= S_DEAD;
            dead_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (frame_tick) begin
            case (dir_q)
              D_UP:    y_q <= y_q - HOP_STEP;
              D_DOWN:  y_q <= y_q + HOP_STEP;
              D_LEFT:  x_q <= x_q - HOP_STEP;
              D_RIGHT: x_q <= x_q + HOP_STEP;
              default: ;
            endcase
            if (cnt_q == HOP_LAST) begin
              state_q    <= S_IDLE;
              cnt_q      <= '0;
              hop_done_q <= 1'b1;
              hop_up_q   <= (dir_q == D_UP);
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_DEAD: begin
          if (frame_tick) begin
            if (cnt_q == DEATH_LAST) begin
              cnt_q <= '0;
              if (lives_q == 2'd1) begin
                lives_q <= 2'd0;
                state_q <= S_OVER;
                over_q  <= 1'b1;
              end else begin
                lives_q <= lives_q - 2'd1;
                x_q     <= START_X;
                y_q     <= START_Y;
                dead_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: ; // S_OVER holds until reset
      endcase
    end
  end

  assign BallX       = x_q;
  assign BallY       = y_q;
  assign dead        = dead_q;
  assign lives       = lives_q;
  assign game_over   = over_q;
  assign hop_done    = hop_done_q;
  assign hop_up      = hop_up_q;
  assign dbg_state_o = state_q;

endmodule
